// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_stage_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } mem_state_e;

    localparam logic [1:0] WORD_ALIGN_MASK        = 2'b11;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 16;

    // Width needed for a counter that must reach timeout_cycles.
    function automatic int cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register: loads a bubble, a faulted instruction, or a
// normally completed instruction on every clock edge.
module mem_wb_pipe_reg
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_bubble,
    input  logic        load_fault,
    input  logic        in_valid,
    input  logic        in_reg_write,
    input  logic [4:0]  in_reg_addr,
    input  logic        in_mem_to_reg,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_load_data,
    output logic        valid,
    output logic        reg_write,
    output logic [4:0]  reg_addr,
    output logic [31:0] result,
    output logic        excp
);

    logic        valid_d, valid_q;
    logic        reg_write_d, reg_write_q;
    logic [4:0]  reg_addr_d, reg_addr_q;
    logic [31:0] result_d, result_q;
    logic        excp_d, excp_q;

    always_comb begin
        valid_d     = in_valid;
        reg_write_d = in_reg_write & in_valid;
        reg_addr_d  = in_reg_addr;
        result_d    = in_mem_to_reg ? in_load_data : in_alu_result;
        excp_d      = 1'b0;

        if (load_bubble) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            reg_addr_d  = 5'd0;
            result_d    = 32'd0;
            excp_d      = 1'b0;
        end else if (load_fault) begin
            // A faulted instruction still retires so WB can raise the exception.
            valid_d     = 1'b1;
            reg_write_d = 1'b0;
            result_d    = in_alu_result;
            excp_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            reg_addr_q  <= 5'd0;
            result_q    <= 32'd0;
            excp_q      <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            reg_addr_q  <= reg_addr_d;
            result_q    <= result_d;
            excp_q      <= excp_d;
        end
    end

    assign valid     = valid_q;
    assign reg_write = reg_write_q;
    assign reg_addr  = reg_addr_q;
    assign result    = result_q;
    assign excp      = excp_q;

endmodule

// File: rtl/mem_pipe_stage.sv
// MEM stage: word loads/stores over a req/ack bus with wait-state stalls,
// timeout abort, and fault detection feeding the MEM/WB register.
module mem_pipe_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_store_data,
    input  logic        ex_mem_mem_read,
    input  logic        ex_mem_mem_write,
    input  logic        ex_mem_mem_to_reg,
    input  logic        ex_mem_reg_write,
    input  logic [4:0]  ex_mem_write_reg_addr,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    input  logic [31:0] dbus_rdata,
    input  logic        dbus_ack,
    output logic        mem_stall,
    output logic        mem_wb_valid,
    output logic        mem_wb_reg_write,
    output logic [4:0]  mem_wb_write_reg_addr,
    output logic [31:0] mem_wb_write_back_result,
    output logic        mem_wb_excp
);

    localparam int             CW       = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_e     state_d, state_q;
    logic [CW-1:0]  cnt_d, cnt_q;
    logic           rst_done_d, rst_done_q;

    logic memop, illegal, misaligned, fault_now;
    logic timeout_hit, abort;

    always_comb begin
        memop       = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);
        illegal     = ex_mem_mem_read & ex_mem_mem_write;
        misaligned  = |(ex_mem_alu_result[1:0] & WORD_ALIGN_MASK);
        fault_now   = memop & (illegal | misaligned);
        dbus_req    = rst_done_q & memop & ~fault_now &
                      ((state_q == IDLE) | (state_q == WAIT_ACK));
        timeout_hit = (state_q == WAIT_ACK) && (cnt_q == CNT_LAST);
        // Ack in the timeout cycle counts as completion.
        abort       = dbus_req & ~dbus_ack & timeout_hit;
        mem_stall   = dbus_req & ~dbus_ack & ~timeout_hit;
    end

    assign dbus_we    = ex_mem_mem_write;
    assign dbus_addr  = {ex_mem_alu_result[31:2], ex_mem_alu_result[1:0] & ~WORD_ALIGN_MASK};
    assign dbus_wdata = ex_mem_store_data;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rst_done_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (dbus_req && !dbus_ack) begin
                    state_d = WAIT_ACK;
                    cnt_d   = '0;
                end
            end
            WAIT_ACK: begin
                if (!dbus_req || dbus_ack || timeout_hit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_done_q <= rst_done_d;
        end
    end

    mem_wb_pipe_reg u_mem_wb (
        .clk           (clk),
        .reset         (reset),
        .load_bubble   (mem_stall),
        .load_fault    (fault_now | abort),
        .in_valid      (ex_mem_valid),
        .in_reg_write  (ex_mem_reg_write),
        .in_reg_addr   (ex_mem_write_reg_addr),
        .in_mem_to_reg (ex_mem_mem_to_reg),
        .in_alu_result (ex_mem_alu_result),
        .in_load_data  (dbus_rdata),
        .valid         (mem_wb_valid),
        .reg_write     (mem_wb_reg_write),
        .reg_addr      (mem_wb_write_reg_addr),
        .result        (mem_wb_write_back_result),
        .excp          (mem_wb_excp)
    );

endmodule

// File: tb/tb_mem_pipe_stage.sv
// Self-checking bench for mem_pipe_stage against a transaction-level model.
module tb_mem_pipe_stage;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        ex_mem_valid;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_store_data;
    logic        ex_mem_mem_read;
    logic        ex_mem_mem_write;
    logic        ex_mem_mem_to_reg;
    logic        ex_mem_reg_write;
    logic [4:0]  ex_mem_write_reg_addr;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        mem_stall;
    logic        mem_wb_valid;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_write_reg_addr;
    logic [31:0] mem_wb_write_back_result;
    logic        mem_wb_excp;

    int passed = 0;
    int total  = 0;

    mem_pipe_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .ex_mem_valid             (ex_mem_valid),
        .ex_mem_alu_result        (ex_mem_alu_result),
        .ex_mem_store_data        (ex_mem_store_data),
        .ex_mem_mem_read          (ex_mem_mem_read),
        .ex_mem_mem_write         (ex_mem_mem_write),
        .ex_mem_mem_to_reg        (ex_mem_mem_to_reg),
        .ex_mem_reg_write         (ex_mem_reg_write),
        .ex_mem_write_reg_addr    (ex_mem_write_reg_addr),
        .dbus_req                 (dbus_req),
        .dbus_we                  (dbus_we),
        .dbus_addr                (dbus_addr),
        .dbus_wdata               (dbus_wdata),
        .dbus_rdata               (dbus_rdata),
        .dbus_ack                 (dbus_ack),
        .mem_stall                (mem_stall),
        .mem_wb_valid             (mem_wb_valid),
        .mem_wb_reg_write         (mem_wb_reg_write),
        .mem_wb_write_reg_addr    (mem_wb_write_reg_addr),
        .mem_wb_write_back_result (mem_wb_write_back_result),
        .mem_wb_excp              (mem_wb_excp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idle_inputs();
        ex_mem_valid          = 1'b0;
        ex_mem_alu_result     = 32'd0;
        ex_mem_store_data     = 32'd0;
        ex_mem_mem_read       = 1'b0;
        ex_mem_mem_write      = 1'b0;
        ex_mem_mem_to_reg     = 1'b0;
        ex_mem_reg_write      = 1'b0;
        ex_mem_write_reg_addr = 5'd0;
        dbus_ack              = 1'b0;
        dbus_rdata            = 32'd0;
    endtask

    // One instruction through MEM; waits = no-ack cycles before the bus acks.
    // Entered and left at posedge+1.
    task automatic run_op(input string name, input logic v, input logic rd, input logic wr,
                          input logic m2r, input logic rw, input logic [4:0] ra,
                          input logic [31:0] alu, input logic [31:0] sd,
                          input logic [31:0] rdata, input int waits);
        logic        memop, fault, bus, timed_out;
        int          stalls;
        logic        e_valid, e_rw, e_excp;
        logic [31:0] e_res;
        logic [1:0]  low;
        low       = alu[1:0];
        memop     = v & (rd | wr);
        fault     = memop & ((rd & wr) | (low != 2'b00));
        bus       = memop & ~fault;
        timed_out = 1'b0;
        stalls    = 0;
        if (bus) begin
            if (waits <= TO) stalls = waits;
            else begin
                stalls    = TO;
                timed_out = 1'b1;
            end
        end
        if (fault || timed_out) begin
            e_valid = 1'b1; e_rw = 1'b0; e_excp = 1'b1; e_res = alu;
        end else begin
            e_valid = v; e_rw = rw & v; e_excp = 1'b0; e_res = m2r ? rdata : alu;
        end

        ex_mem_valid          = v;
        ex_mem_mem_read       = rd;
        ex_mem_mem_write      = wr;
        ex_mem_mem_to_reg     = m2r;
        ex_mem_reg_write      = rw;
        ex_mem_write_reg_addr = ra;
        ex_mem_alu_result     = alu;
        ex_mem_store_data     = sd;
        for (int cyc = 0; cyc <= stalls; cyc++) begin
            dbus_ack   = (cyc == waits);
            dbus_rdata = (cyc == waits) ? rdata : $urandom;
            #1;
            total++;
            if (dbus_req !== bus) $display("[TB] FAIL %s req cyc%0d: got %b want %b", name, cyc, dbus_req, bus);
            else passed++;
            total++;
            if (mem_stall !== (cyc < stalls)) $display("[TB] FAIL %s stall cyc%0d: got %b want %b", name, cyc, mem_stall, (cyc < stalls));
            else passed++;
            if (bus) begin
                total++;
                if (dbus_we !== wr || dbus_addr !== (alu & 32'hFFFF_FFFC) || dbus_wdata !== sd)
                    $display("[TB] FAIL %s bus fields: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                             name, dbus_we, dbus_addr, dbus_wdata, wr, alu & 32'hFFFF_FFFC, sd);
                else passed++;
            end
            @(posedge clk); #1;
            if (cyc < stalls) begin
                total++;
                if ({mem_wb_valid, mem_wb_reg_write, mem_wb_excp} !== 3'b000 || mem_wb_write_back_result !== 32'd0)
                    $display("[TB] FAIL %s bubble cyc%0d: got v=%b rw=%b ex=%b res=%h want all 0",
                             name, cyc, mem_wb_valid, mem_wb_reg_write, mem_wb_excp, mem_wb_write_back_result);
                else passed++;
            end
        end
        dbus_ack = 1'b0;
        total++;
        if (mem_wb_valid !== e_valid || mem_wb_reg_write !== e_rw || mem_wb_excp !== e_excp ||
            mem_wb_write_back_result !== e_res)
            $display("[TB] FAIL %s mem_wb: got v=%b rw=%b ex=%b res=%h want v=%b rw=%b ex=%b res=%h",
                     name, mem_wb_valid, mem_wb_reg_write, mem_wb_excp, mem_wb_write_back_result,
                     e_valid, e_rw, e_excp, e_res);
        else passed++;
        if (e_rw) begin
            total++;
            if (mem_wb_write_reg_addr !== ra) $display("[TB] FAIL %s wb addr: got %0d want %0d", name, mem_wb_write_reg_addr, ra);
            else passed++;
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({dbus_req, mem_stall, mem_wb_valid, mem_wb_reg_write, mem_wb_excp} !== 5'b0 ||
            mem_wb_write_reg_addr !== 5'd0 || mem_wb_write_back_result !== 32'd0)
            $display("[TB] FAIL %s: got req=%b stall=%b v=%b rw=%b ex=%b ra=%0d res=%h want all 0", name,
                     dbus_req, mem_stall, mem_wb_valid, mem_wb_reg_write, mem_wb_excp,
                     mem_wb_write_reg_addr, mem_wb_write_back_result);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        ex_mem_valid      = 1'b1;
        ex_mem_mem_read   = 1'b1;
        ex_mem_alu_result = 32'h40;
        #2;
        check_all_zero("reset_state");
        #10 reset = 1'b1;
        #1;
        total++;
        if (dbus_req !== 1'b0) $display("[TB] FAIL req_before_first_edge: got %b want 0", dbus_req);
        else passed++;
        idle_inputs();
        @(posedge clk); #1;
        run_op("pre_reset_alu", 1, 0, 0, 0, 1, 5'd3, 32'h55, 32'h0, 32'h0, 0);
        reset = 1'b0;
        #1;
        check_all_zero("async_reset_clears_mem_wb");
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait_load();
        run_op("zero_wait_load", 1, 1, 0, 1, 1, 5'd5, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    endtask

    task automatic test_wait_store();
        run_op("three_wait_store", 1, 0, 1, 0, 0, 5'd0, 32'h204, 32'h12345678, 32'h0, 3);
    endtask

    task automatic test_timeout();
        run_op("timeout_load", 1, 1, 0, 1, 1, 5'd6, 32'h400, 32'h0, 32'h11111111, 1000);
        idle_inputs();
        #1;
        total++;
        if (dbus_req !== 1'b0 || mem_stall !== 1'b0)
            $display("[TB] FAIL timeout_req_drops: got req=%b stall=%b want 0 0", dbus_req, mem_stall);
        else passed++;
        @(posedge clk); #1;
        run_op("after_timeout_load", 1, 1, 0, 1, 1, 5'd7, 32'h408, 32'h0, 32'h0BADF00D, 1);
        run_op("ack_at_timeout_wins", 1, 1, 0, 1, 1, 5'd8, 32'h40C, 32'h0, 32'hA5A5A5A5, TO);
    endtask

    task automatic test_faults();
        run_op("misaligned_load", 1, 1, 0, 1, 1, 5'd4, 32'h103, 32'h0, 32'h22222222, 0);
        run_op("illegal_rw", 1, 1, 1, 1, 1, 5'd4, 32'h200, 32'h9, 32'h33333333, 0);
        run_op("misaligned_store", 1, 0, 1, 0, 0, 5'd0, 32'h302, 32'h44, 32'h0, 0);
    endtask

    task automatic test_alu_pass();
        run_op("alu_pass", 1, 0, 0, 0, 1, 5'd9, 32'h0000002A, 32'h0, 32'h0, 0);
        run_op("bubble_ack_ignored", 0, 1, 0, 0, 1, 5'd2, 32'h500, 32'h0, 32'h0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int          kind;
            int          w;
            logic [31:0] a;
            logic [4:0]  r;
            kind = $urandom_range(0, 9);
            w    = $urandom_range(0, TO + 2);
            a    = $urandom & 32'hFFFF_FFFC;
            r    = 5'($urandom_range(0, 31));
            case (kind)
                0:       run_op("rnd_alu", 1, 0, 0, 0, 1'($urandom), r, $urandom, $urandom, $urandom, 0);
                1:       run_op("rnd_bubble", 0, 1'($urandom), 0, 0, 1'($urandom), r, a, $urandom, $urandom, 0);
                2, 3, 4: run_op("rnd_load", 1, 1, 0, 1'($urandom), 1'($urandom), r, a, $urandom, $urandom, w);
                5, 6, 7: run_op("rnd_store", 1, 0, 1, 0, 0, r, a, $urandom, $urandom, w);
                8:       run_op("rnd_misaligned", 1, 1'($urandom), 1, 0, 1, r, a | 32'(1 + $urandom_range(0, 2)), $urandom, $urandom, 0);
                default: run_op("rnd_illegal", 1, 1, 1, 1, 1, r, a, $urandom, $urandom, 0);
            endcase
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        ex_mem_valid          = 1'b1;
        ex_mem_mem_read       = 1'b1;
        ex_mem_mem_to_reg     = 1'b1;
        ex_mem_reg_write      = 1'b1;
        ex_mem_write_reg_addr = 5'd7;
        ex_mem_alu_result     = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b0;
        #1;
        check_all_zero("reset_mid_wait");
        #1 reset = 1'b1;
        #1;
        total++;
        if (dbus_req !== 1'b0 || mem_stall !== 1'b0)
            $display("[TB] FAIL req_after_release: got req=%b stall=%b want 0 0", dbus_req, mem_stall);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (dbus_req !== 1'b1 || mem_stall !== 1'b1)
            $display("[TB] FAIL req_one_cycle_later: got req=%b stall=%b want 1 1", dbus_req, mem_stall);
        else passed++;
        @(posedge clk); #1;
        dbus_ack   = 1'b1;
        dbus_rdata = 32'hCAFEF00D;
        #1;
        total++;
        if (mem_stall !== 1'b0) $display("[TB] FAIL post_reset_ack_stall: got %b want 0", mem_stall);
        else passed++;
        @(posedge clk); #1;
        total++;
        if (mem_wb_write_back_result !== 32'hCAFEF00D || mem_wb_valid !== 1'b1 ||
            mem_wb_reg_write !== 1'b1 || mem_wb_write_reg_addr !== 5'd7)
            $display("[TB] FAIL post_reset_load: got v=%b rw=%b ra=%0d res=%h want v=1 rw=1 ra=7 res=cafef00d",
                     mem_wb_valid, mem_wb_reg_write, mem_wb_write_reg_addr, mem_wb_write_back_result);
        else passed++;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_wait_store();
        test_timeout();
        test_faults();
        test_alu_pass();
        test_random();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_pipe_stage.md
Name: mem_pipe_stage

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the EX stage.
- Takes the registered ALU result (used as the address) and the forwarded store data (EX alu_in2_out) from the EX/MEM register.
- Runs word loads/stores over a req/ack data bus, stalling the pipeline for wait states, with an abort on timeout.
- Drives the MEM/WB register, including the mem_wb_write_back_result that feeds the EX forwarding muxes.

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT_ACK cycles before a bus access is aborted; legal range 1..255.

Ports:
- clk  in  1  Pipeline clock; rising edge.
- reset  in  1  Asynchronous, active-low reset.
- ex_mem_valid  in  1  EX/MEM holds a real instruction.
- ex_mem_alu_result  in  32  ALU result; byte address for loads/stores.
- ex_mem_store_data  in  32  Store data.
- ex_mem_mem_read  in  1  Load.
- ex_mem_mem_write  in  1  Store.
- ex_mem_mem_to_reg  in  1  Write-back selects load data.
- ex_mem_reg_write  in  1  Instruction writes the register file.
- ex_mem_write_reg_addr  in  5  Destination register.
- dbus_req  out  1  Bus request.
- dbus_we  out  1  1 = write.
- dbus_addr  out  32  Word address; bits [1:0] are always 0.
- dbus_wdata  out  32  Store data.
- dbus_rdata  in  32  Load data; valid when dbus_ack=1.
- dbus_ack  in  1  Access complete.
- mem_stall  out  1  Freezes PC, IF/ID, ID/EX and EX/MEM.
- mem_wb_valid  out  1  MEM/WB holds a real instruction.
- mem_wb_reg_write  out  1  Register-file write enable to WB.
- mem_wb_write_reg_addr  out  5  Destination register.
- mem_wb_write_back_result  out  32  Write-back value; also a forwarding source.
- mem_wb_excp  out  1  Instruction faulted (misaligned, illegal, or timeout).

Behaviour:
- Decode
  - memop = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write).
  - illegal = mem_read & mem_write both set.
  - misaligned = alu_result[1:0] != 0.
  - fault_now = memop & (illegal | misaligned).
  - A faulting op never touches the bus.
- Bus outputs
  - dbus_req = rst_done & memop & !fault_now & (state==IDLE | state==WAIT_ACK).
  - rst_done is a flop cleared by reset and set on the first clock edge after reset release, so dbus_req is 0 during reset.
  - dbus_we = mem_write; dbus_addr = {alu_result[31:2], 2'b00}; dbus_wdata = store_data.
  - All bus outputs are combinational from the EX/MEM inputs.
- FSM states: IDLE, WAIT_ACK. Reset state is IDLE and the timeout counter is 0.
- IDLE transitions
  - dbus_req & dbus_ack: zero-wait completion; no stall.
  - dbus_req & !dbus_ack: go to WAIT_ACK, counter <= 0.
- WAIT_ACK transitions
  - Each cycle without ack: counter increments.
  - dbus_ack: complete and go to IDLE.
  - No ack with counter == TIMEOUT_CYCLES-1: abort, go to IDLE, counter <= 0.
- Stall
  - mem_stall = dbus_req & !dbus_ack & !timeout_hit.
  - Upstream registers are frozen while stalled, so the EX/MEM inputs are stable throughout WAIT_ACK.
- MEM/WB register (updates on every clock edge)
  - Stalled: load a bubble (valid=0, reg_write=0, excp=0, result=0).
  - Normal completion, or non-memory instruction:
    - valid = ex_mem_valid.
    - reg_write = ex_mem_reg_write & ex_mem_valid.
    - result = mem_to_reg ? dbus_rdata : alu_result.
    - excp = 0.
  - Fault or timeout:
    - valid = 1, reg_write = 0, excp = 1, result = alu_result.
- Latency: one cycle from EX/MEM to MEM/WB, plus N stall cycles for N bus wait states.
- Ack rules
  - dbus_ack while dbus_req=0 is ignored.
  - Ack in the same cycle as timeout_hit counts as completion: ack wins.
- Reset mid-access: FSM returns to IDLE, the MEM/WB outputs go to 0, and the outstanding bus transaction is abandoned.
- Reset value of every registered output is 0.

Decomposition:
- Package mem_stage_pkg holds:
  - state enum {IDLE, WAIT_ACK};
  - WORD_ALIGN_MASK = 2'b11;
  - a localparam helper for the counter width ($clog2(TIMEOUT_CYCLES+1)).
- Sub-module mem_wb_pipe_reg holds the MEM/WB flops with bubble-load control.
- FSM, counter and bus logic stay in mem_pipe_stage.

Test Plan:
- Zero-wait load:
  - Stimulus: valid=1, mem_read=1, alu_result=0x100, mem_to_reg=1, reg=5, bus acks in the same cycle with rdata=0xDEADBEEF.
  - Response: mem_stall never asserts; next cycle mem_wb_write_back_result=0xDEADBEEF, reg_write=1, addr=5.
- 3-wait store:
  - Stimulus: mem_write=1, addr=0x204, data=0x12345678, ack arrives on the 4th req cycle.
  - Response: dbus_we=1, dbus_addr=0x204, mem_stall high for 3 cycles; MEM/WB holds bubbles during the stall, then valid=1, reg_write=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, load, no ack.
  - Response: stall for 4 cycles; then excp=1, reg_write=0, FSM back in IDLE, dbus_req drops once EX/MEM advances.
- Misaligned and illegal:
  - Stimulus: alu_result=0x103 with mem_read=1; separately, mem_read=mem_write=1.
  - Response: dbus_req stays 0, no stall, next cycle excp=1, reg_write=0.
- ALU pass-through:
  - Stimulus: R-type, alu_result=0x0000002A, reg_write=1, reg=9.
  - Response: next cycle result=0x2A, reg_write=1, addr=9, no bus activity.
- Reset mid-wait:
  - Stimulus: reset asserted in the 2nd WAIT_ACK cycle.
  - Response: all outputs 0 immediately, no clock edge required; after release, dbus_req stays 0 for one cycle.
